hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller in the ID stage, directly upstream of the ID/EX pipeline register.
- Detects load-use hazards between the instruction in ID (IF/ID) and the one in EX (ID/EX).
- Drives the PC write enable, the IF/ID write enable and flush, and `ctr_sel` (1 = pass controls, 0 = insert bubble) into ID/EX.
- Runs a small FSM for multi-cycle load-use stalls, handles taken-branch flushes, and keeps saturating stall and flush performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (range 1..15)
- CNT_WIDTH, 16, width of each performance counter

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- IF_ID_inst_opcode  in  7  opcode of the instruction in ID
- IF_ID_rs1  in  REG_ADDR_WIDTH  source register 1 of the ID instruction
- IF_ID_rs2  in  REG_ADDR_WIDTH  source register 2 of the ID instruction
- ID_EX_inst_opcode  in  7  opcode held in ID/EX
- ID_EX_rd  in  REG_ADDR_WIDTH  destination register held in ID/EX
- ID_EX_reg_write_en  in  1  register write enable held in ID/EX
- ex_branch_taken  in  1  EX redirects the PC this cycle
- pc_write_en  out  1  PC register update enable
- if_id_write_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID register clears to NOP
- ctr_sel  out  1  to ID/EX: 1 = pass controls, 0 = bubble
- hz_state  out  2  current FSM state (RUN=0, STALL=1)
- stall_count  out  CNT_WIDTH  total bubble cycles caused by load-use hazards
- flush_count  out  CNT_WIDTH  total taken-branch flushes

Behaviour:
- Reset (asynchronous, active-low):
  - state = RUN; remaining-stall counter = 0; stall_count = 0; flush_count = 0.
  - Outputs read as RUN with no hazard: pc_write_en=1, if_id_write_en=1, if_id_flush=0, ctr_sel=1.
- Register usage, decoded from IF_ID_inst_opcode:
  - rs1 used by R-type 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111.
  - rs2 used by R-type, STORE, BRANCH.
  - No other opcode uses rs1 or rs2.
- load_use is true when all of the following hold:
  - ID_EX_inst_opcode == 0000011;
  - ID_EX_reg_write_en == 1. This gate is required because ID/EX passes the opcode through even during a bubble;
  - ID_EX_rd != 0;
  - ID_EX_rd matches a used rs1 or a used rs2.
- Outputs are combinational from state and inputs; state, counters and performance counters are registered.
- RUN state:
  - ex_branch_taken=1 (highest priority): if_id_flush=1, ctr_sel=0, pc_write_en=1, if_id_write_en=1; flush_count++; stay in RUN. load_use is ignored in this cycle.
  - Otherwise, if load_use: pc_write_en=0, if_id_write_en=0, ctr_sel=0; stall_count++.
    - If LOAD_STALL_CYCLES > 1: go to STALL and load the counter with LOAD_STALL_CYCLES-1.
    - Otherwise stay in RUN.
  - Otherwise all outputs are at their pass values.
- STALL state:
  - Outputs held as in the stall case above; stall_count++; counter decrements; load_use is ignored.
  - When the counter == 1, next state is RUN.
  - Total bubbles per hazard = LOAD_STALL_CYCLES, back to back.
- ex_branch_taken=1 in STALL (not expected, since EX holds a bubble):
  - Flush wins: flush outputs as in RUN, go to RUN, clear the counter, flush_count++.
- Performance counters saturate at all-ones and never wrap.
- Reset asserted mid-stall: immediately RUN with pass outputs. A stall in progress is abandoned.
- ctr_sel=0 and if_id_flush=1 are never both the result of a load-use stall. if_id_flush is asserted only for a branch flush.

Decomposition:
- Shared package risc_v_pkg holds:
  - opcode constants OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_OP, OPC_OP_IMM;
  - the hz_state enum {HZ_RUN, HZ_STALL}.
- One combinational sub-module, hazard_detect: takes the opcodes, register indices and write enable, and produces load_use.
- The FSM, stall counter and performance counters stay in hazard_ctrl.

Test Plan:
- LOAD_STALL_CYCLES=1; ID_EX LOAD rd=5, reg_write_en=1; IF_ID ADD rs1=5 -> one cycle with pc_write_en=0, if_id_write_en=0, ctr_sel=0; next cycle (ID_EX reg_write_en=0) all pass values; stall_count=1.
- LOAD_STALL_CYCLES=3; same hazard -> exactly 3 consecutive stall cycles, hz_state sequence 0,1,1,0; stall_count=3.
- ID_EX LOAD rd=0 with IF_ID rs1=0, and separately ID_EX LOAD rd=7 with IF_ID LUI 0110111 -> no stall; ID_EX LOAD rd=7 with IF_ID STORE rs2=7 -> stall.
- ex_branch_taken=1 while load_use is also true -> if_id_flush=1, ctr_sel=0, pc_write_en=1; flush_count=1; stall_count unchanged.
- LOAD_STALL_CYCLES=4; reset_n pulled low in the 2nd stall cycle -> outputs return to pass values immediately, hz_state=0, both counters=0.
- CNT_WIDTH=4; 20 branch flushes -> flush_count stops at 15.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Shared RISC-V opcode constants, hazard FSM state encoding and register-usage decode.
// Pure definitions: no latency, no flow control.
package risc_v_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1
    } hz_state_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the ID instruction and the load held in ID/EX.
// Purely combinational, zero latency, no backpressure.
module hazard_detect
    import risc_v_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic [6:0]                ID_EX_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      ID_EX_reg_write_en,
    output logic                      load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = uses_rs1(IF_ID_inst_opcode) && (IF_ID_rs1 == ID_EX_rd);
    assign rs2_hit = uses_rs2(IF_ID_inst_opcode) && (IF_ID_rs2 == ID_EX_rd);

    // Write enable gates out bubbles, which still carry the load opcode through ID/EX.
    assign load_use = (ID_EX_inst_opcode == OPC_LOAD) && ID_EX_reg_write_en
                   && (ID_EX_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard control: load-use stalls (LOAD_STALL_CYCLES bubbles) and branch flushes.
// Outputs are combinational from state and inputs; state and saturating perf counters update on clk.
module hazard_ctrl
    import risc_v_pkg::*;
#(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic [6:0]                ID_EX_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      ID_EX_reg_write_en,
    input  logic                      ex_branch_taken,
    output logic                      pc_write_en,
    output logic                      if_id_write_en,
    output logic                      if_id_flush,
    output logic                      ctr_sel,
    output logic [1:0]                hz_state,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    hz_state_t  state;
    logic [3:0] stall_left;
    logic       load_use;

    hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_detect (
        .IF_ID_inst_opcode  (IF_ID_inst_opcode),
        .IF_ID_rs1          (IF_ID_rs1),
        .IF_ID_rs2          (IF_ID_rs2),
        .ID_EX_inst_opcode  (ID_EX_inst_opcode),
        .ID_EX_rd           (ID_EX_rd),
        .ID_EX_reg_write_en (ID_EX_reg_write_en),
        .load_use           (load_use)
    );

    assign hz_state = state;

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        ctr_sel        = 1'b1;
        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            ctr_sel     = 1'b0;
        end else if (state == HZ_STALL || load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            ctr_sel        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HZ_RUN;
            stall_left  <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (ex_branch_taken) begin
            // A redirect squashes any stall still in progress.
            state      <= HZ_RUN;
            stall_left <= '0;
            if (flush_count != '1) flush_count <= flush_count + 1'b1;
        end else if (state == HZ_STALL) begin
            if (stall_count != '1) stall_count <= stall_count + 1'b1;
            stall_left <= stall_left - 4'd1;
            if (stall_left == 4'd1) state <= HZ_RUN;
        end else if (load_use) begin
            if (stall_count != '1) stall_count <= stall_count + 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state      <= HZ_STALL;
                stall_left <= STALL_RELOAD;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic        cs;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    typedef struct packed {
        exp_t e2;
        exp_t e1;
        exp_t e0;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [6:0] ifid_opc, idex_opc;
    logic [4:0] rs1, rs2, rd;
    logic       we, br;

    logic       pcw [3];
    logic       ifw [3];
    logic       fl  [3];
    logic       cs  [3];
    logic [1:0] hs  [3];
    logic [15:0] sc0, fc0, sc2, fc2;
    logic [3:0]  sc1, fc1;

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(1), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_inst_opcode(ifid_opc), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .ID_EX_inst_opcode(idex_opc), .ID_EX_rd(rd), .ID_EX_reg_write_en(we),
        .ex_branch_taken(br),
        .pc_write_en(pcw[0]), .if_id_write_en(ifw[0]), .if_id_flush(fl[0]), .ctr_sel(cs[0]),
        .hz_state(hs[0]), .stall_count(sc0), .flush_count(fc0));

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(3), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_inst_opcode(ifid_opc), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .ID_EX_inst_opcode(idex_opc), .ID_EX_rd(rd), .ID_EX_reg_write_en(we),
        .ex_branch_taken(br),
        .pc_write_en(pcw[1]), .if_id_write_en(ifw[1]), .if_id_flush(fl[1]), .ctr_sel(cs[1]),
        .hz_state(hs[1]), .stall_count(sc1), .flush_count(fc1));

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(4), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_inst_opcode(ifid_opc), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .ID_EX_inst_opcode(idex_opc), .ID_EX_rd(rd), .ID_EX_reg_write_en(we),
        .ex_branch_taken(br),
        .pc_write_en(pcw[2]), .if_id_write_en(ifw[2]), .if_id_flush(fl[2]), .ctr_sel(cs[2]),
        .hz_state(hs[2]), .stall_count(sc2), .flush_count(fc2));

    // Reference model: bubbles still owed and counters per instance, plain integers.
    int   lsc [3] = '{1, 3, 4};
    int   cap [3] = '{65535, 15, 65535};
    int   owed [3];
    int   m_sc [3];
    int   m_fc [3];
    cyc_t sb_q [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t pick(input cyc_t c, input int i);
        if (i == 0) return c.e0;
        if (i == 1) return c.e1;
        return c.e2;
    endfunction

    function automatic exp_t actual(input int i);
        exp_t a;
        a.pcw = pcw[i]; a.ifw = ifw[i]; a.fl = fl[i]; a.cs = cs[i]; a.st = hs[i];
        a.sc  = (i == 0) ? sc0 : (i == 1) ? {12'b0, sc1} : sc2;
        a.fc  = (i == 0) ? fc0 : (i == 1) ? {12'b0, fc1} : fc2;
        return a;
    endfunction

    task automatic chk(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", name, inst, $time, got, exp);
        end
    endtask

    task automatic cmp(input exp_t a, input exp_t e, input int i);
        chk("pc_write_en",    i, int'(a.pcw), int'(e.pcw));
        chk("if_id_write_en", i, int'(a.ifw), int'(e.ifw));
        chk("if_id_flush",    i, int'(a.fl),  int'(e.fl));
        chk("ctr_sel",        i, int'(a.cs),  int'(e.cs));
        chk("hz_state",       i, int'(a.st),  int'(e.st));
        chk("stall_count",    i, int'(a.sc),  int'(e.sc));
        chk("flush_count",    i, int'(a.fc),  int'(e.fc));
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0; e.cs = 1'b1;
        e.st = 2'd0; e.sc = 16'd0; e.fc = 16'd0;
        return e;
    endfunction

    function automatic bit ref_load_use(input logic [6:0] io, input logic [4:0] a, input logic [4:0] b,
                                        input logic [6:0] eo, input logic [4:0] d, input logic w);
        bit u1, u2;
        u1 = io inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        u2 = io inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (eo == 7'b0000011) && w && (d != 5'd0) && ((u1 && a == d) || (u2 && b == d));
    endfunction

    // Monitor: one expected entry per cycle, compared away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                cyc_t c;
                c = sb_q.pop_front();
                for (int i = 0; i < 3; i++) cmp(actual(i), pick(c, i), i);
            end
        end
    end

    task automatic step(input logic [6:0] io, input logic [4:0] a, input logic [4:0] b,
                        input logic [6:0] eo, input logic [4:0] d, input logic w, input logic bt);
        cyc_t c;
        exp_t e [3];
        bit   lu;
        @(posedge clk);
        #1;
        ifid_opc = io; rs1 = a; rs2 = b; idex_opc = eo; rd = d; we = w; br = bt;
        lu = ref_load_use(io, a, b, eo, d, w);
        for (int i = 0; i < 3; i++) begin
            e[i] = reset_exp();
            e[i].st = (owed[i] > 0) ? 2'd1 : 2'd0;
            e[i].sc = 16'(m_sc[i]);
            e[i].fc = 16'(m_fc[i]);
            if (bt) begin
                e[i].fl = 1'b1; e[i].cs = 1'b0;
                owed[i] = 0;
                if (m_fc[i] < cap[i]) m_fc[i]++;
            end else if (owed[i] > 0 || lu) begin
                e[i].pcw = 1'b0; e[i].ifw = 1'b0; e[i].cs = 1'b0;
                owed[i] = (owed[i] > 0) ? owed[i] - 1 : lsc[i] - 1;
                if (m_sc[i] < cap[i]) m_sc[i]++;
            end
        end
        c.e0 = e[0]; c.e1 = e[1]; c.e2 = e[2];
        sb_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(7'h13, 5'd0, 5'd0, 7'h13, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            owed[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 3; i++) cmp(actual(i), reset_exp(), i);
    endtask

    logic [6:0] opc_tbl [8];

    initial begin
        opc_tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1100111, 7'b0110111, 7'b0000011};
        model_reset();
        reset_n = 1'b0;
        ifid_opc = 7'h13; rs1 = 0; rs2 = 0; idex_opc = 7'h13; rd = 0; we = 0; br = 0;
        #2;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        idle(2);
        // Basic load-use: LOAD x5 in EX, ADD using x5 in ID, then bubble in EX.
        step(7'b0110011, 5'd5, 5'd1, 7'b0000011, 5'd5, 1'b1, 1'b0);
        step(7'b0110011, 5'd5, 5'd1, 7'b0000011, 5'd5, 1'b0, 1'b0);
        idle(5);
        // rd = x0 never hazards; LUI reads nothing; STORE rs2 does.
        step(7'b0110011, 5'd0, 5'd0, 7'b0000011, 5'd0, 1'b1, 1'b0);
        step(7'b0110111, 5'd7, 5'd7, 7'b0000011, 5'd7, 1'b1, 1'b0);
        step(7'b0100011, 5'd1, 5'd7, 7'b0000011, 5'd7, 1'b1, 1'b0);
        idle(5);
        // Branch flush wins over a simultaneous load-use.
        step(7'b0110011, 5'd5, 5'd1, 7'b0000011, 5'd5, 1'b1, 1'b1);
        idle(2);
        // Saturation of the 4-bit flush counter.
        for (int k = 0; k < 20; k++) step(7'h13, 5'd0, 5'd0, 7'h13, 5'd0, 1'b0, 1'b1);
        idle(2);
        // Reset during the second stall cycle.
        step(7'b0110011, 5'd5, 5'd1, 7'b0000011, 5'd5, 1'b1, 1'b0);
        step(7'b0110011, 5'd5, 5'd1, 7'b0000011, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        #1 reset_n = 1'b1;

        for (int k = 0; k < 400; k++) begin
            step(opc_tbl[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0) ? 7'b0000011 : opc_tbl[$urandom_range(0, 7)],
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end
        idle(1);

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        chk("scoreboard_drain", 0, sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
